label_seq_ctrl: RTL
===================

LABEL_SEQ_CTRL -- requirements
Module: label_seq_ctrl

Interface
REQ-001 Parameters SHALL be ADDR_W, 10, label-memory address width; DATA_W, 16, label word width (Q6.9, 1.0 = 512).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a training sequence.
REQ-005 abort  input  1  terminate sequence.
REQ-006 num_samples  input  ADDR_W+1  labels per epoch, 0..1024; values above 1024 are treated as 1024.
REQ-007 num_epochs  input  8  epoch count, 0..255.
REQ-008 busy  output  1  sequence in progress.
REQ-009 done  output  1  one-cycle pulse on normal completion.
REQ-010 epoch_idx  output  8  current epoch, 0-based.
REQ-011 host_wr_en, host_addr[ADDR_W], host_data[DATA_W]  input  host label-load write request.
REQ-012 host_wr_ack  output  1  host write accepted this cycle (combinational).
REQ-013 mem_ena, wr_rd  output  1 each  memory enable; 1 = write, 0 = read.
REQ-014 addr  output  ADDR_W  memory address.
REQ-015 data_in  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read-enable edge.
REQ-017 lbl_valid, lbl_data[DATA_W], lbl_idx[ADDR_W], lbl_last  output  label stream to training core.
REQ-018 lbl_ready  input  1  training core accepts label.

Function
REQ-019 FSM states SHALL be IDLE, RD, CAP, PRESENT.
REQ-020 IDLE: start=1 with busy=0 -> if num_samples=0 or num_epochs=0, stay IDLE and pulse done next cycle; else idx=0, epoch_idx=0, go RD.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 RD (one cycle): mem_ena=1, wr_rd=0, addr=idx; go CAP.
REQ-023 CAP (one cycle): register mem_rdata into lbl_data, idx into lbl_idx, lbl_last=(idx=N-1 and epoch_idx=num_epochs-1); go PRESENT.
REQ-024 PRESENT: lbl_valid=1; lbl_data/lbl_idx/lbl_last SHALL be held stable until lbl_valid&lbl_ready.
REQ-025 On handshake: if idx<N-1, idx+1 -> RD; else if epoch_idx<num_epochs-1, idx=0, epoch_idx+1 -> RD; else -> IDLE, done=1 for one cycle.
REQ-026 Label throughput SHALL be at most one per 3 cycles; handshake-to-next-lbl_valid latency = 3 cycles.
REQ-027 num_samples and num_epochs SHALL be sampled at accepted start and held for the sequence.
REQ-028 busy SHALL be 1 in RD, CAP, PRESENT; 0 in IDLE.
REQ-029 Arbitration: sequencer read has priority in RD; host_wr_ack = host_wr_en and state != RD.
REQ-030 On host_wr_ack: mem_ena=1, wr_rd=1, addr=host_addr, data_in=host_data in that cycle.
REQ-031 Host write and sequencer activity in CAP/PRESENT SHALL proceed concurrently; a write to the presented address SHALL NOT alter held lbl_data.
REQ-032 When neither reading nor writing: mem_ena=0, wr_rd=0, addr=0, data_in=0.
REQ-033 abort=1 in any busy state SHALL force IDLE at next edge: lbl_valid=0, no done pulse; abort has priority over handshake and start.
REQ-034 idx and epoch_idx SHALL never wrap; N=1024 terminates at idx=1023.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state=IDLE, idx=0, epoch_idx=0, busy=0, done=0, lbl_valid=0, lbl_data=0, lbl_idx=0, lbl_last=0.
REQ-036 Memory-facing outputs SHALL be 0 during reset except host path, which SHALL be blocked (host_wr_ack=0) while rst_n=0.
REQ-037 Reset mid-sequence SHALL discard progress; next start begins at idx=0, epoch 0.

Verification
REQ-038 Host writes 0x0200,0xFE00,0x0200 to addr 0..2; start, N=3, E=2, lbl_ready=1 -> stream 0x0200,0xFE00,0x0200 twice, epoch_idx 0 then 1, lbl_last only on 6th, done one cycle after 6th handshake.
REQ-039 N=2, E=1, lbl_ready held 0 for 10 cycles in PRESENT -> lbl_data/lbl_idx stable, no new mem_ena read; release -> second label 3 cycles later.
REQ-040 host_wr_en=1 continuously during sequence -> host_wr_ack=0 exactly in RD cycles, 1 otherwise; streamed labels match pre-load.
REQ-041 N=0 or E=0 with start -> no mem_ena, busy stays 0, done pulses once next cycle.
REQ-042 abort in PRESENT at idx=5 -> lbl_valid=0 next cycle, no done; new start restarts at idx=0.
REQ-043 rst_n low mid-CAP (asynchronous, between edges) -> outputs zero immediately; N=1100 after reset -> exactly 1024 labels per epoch.

Source files
------------

// File: rtl/label_seq_ctrl.sv
// Label sequencer: streams label-memory words to the training core for num_epochs
// passes of num_samples labels, sharing the single memory port with host label loads.
module label_seq_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [7:0]        num_epochs,
  output logic              busy,
  output logic              done,
  output logic [7:0]        epoch_idx,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_wr_ack,
  output logic              mem_ena,
  output logic              wr_rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lbl_valid,
  output logic [DATA_W-1:0] lbl_data,
  output logic [ADDR_W-1:0] lbl_idx,
  output logic              lbl_last,
  input  logic              lbl_ready
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned EPOCH_W = 8;
  localparam logic [CNT_W-1:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_CAP     = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [ADDR_W-1:0]    n_last_q, n_last_d;
  logic [EPOCH_W-1:0]   e_last_q, e_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ADDR_W-1:0]    lidx_q, lidx_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     n_eff;

  // Oversized sample counts saturate at the full memory depth.
  assign n_eff = (num_samples > N_MAX) ? N_MAX : num_samples;

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    n_last_d = n_last_q;
    e_last_d = e_last_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    lidx_d   = lidx_q;
    last_d   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (num_samples == '0 || num_epochs == '0) begin
            done_d = 1'b1;
          end else begin
            n_last_d = ADDR_W'(n_eff - CNT_W'(1));
            e_last_d = num_epochs - EPOCH_W'(1);
            idx_d    = '0;
            epoch_d  = '0;
            state_d  = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        data_d  = mem_rdata;
        lidx_d  = idx_q;
        last_d  = (idx_q == n_last_q) && (epoch_q == e_last_q);
        valid_d = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (lbl_ready) begin
          valid_d = 1'b0;
          if (idx_q < n_last_q) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_RD;
          end else if (epoch_q < e_last_q) begin
            idx_d   = '0;
            epoch_d = epoch_q + EPOCH_W'(1);
            state_d = ST_RD;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over handshake and start; it never produces a done pulse.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      epoch_q  <= '0;
      n_last_q <= '0;
      e_last_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      lidx_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      n_last_q <= n_last_d;
      e_last_q <= e_last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      lidx_q   <= lidx_d;
      last_q   <= last_d;
    end
  end

  // Memory port mux: sequencer read owns the port in RD, host writes elsewhere.
  always_comb begin
    host_wr_ack = host_wr_en && rst_n && (state_q != ST_RD);
    mem_ena     = 1'b0;
    wr_rd       = 1'b0;
    addr        = '0;
    data_in     = '0;
    if (rst_n && state_q == ST_RD) begin
      mem_ena = 1'b1;
      addr    = idx_q;
    end else if (host_wr_ack) begin
      mem_ena = 1'b1;
      wr_rd   = 1'b1;
      addr    = host_addr;
      data_in = host_data;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign epoch_idx = epoch_q;
  assign lbl_valid = valid_q;
  assign lbl_data  = data_q;
  assign lbl_idx   = lidx_q;
  assign lbl_last  = last_q;

endmodule
